// File: rtl/fpu_if.sv
// Operand/result bundle for the pipelined binary32 arithmetic unit.
// The master drives operands and opcode; the slave (fpu) returns the registered result.
interface fpu_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [1:0]  opcode;
  logic [31:0] O;

  modport master (output A, output B, output opcode, input O);
  modport slave  (input A, input B, input opcode, output O);
endinterface

// File: rtl/fpu.sv
// Two-stage IEEE-754 binary32 add/sub/mul with flush-to-zero and round-to-nearest-even.
// Stage 1 unpacks, classifies, aligns or multiplies; stage 2 normalises, rounds and packs into O.
module fpu (
  input  logic clk,
  input  logic rst,
  fpu_if.slave bus
);

  localparam int          LATENCY = 2;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;

  if (LATENCY != 2) begin : g_latency_check
    $error("fpu: LATENCY is fixed at 2");
  end

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) n = 5'(26 - i);
    end
    return n;
  endfunction

  // Operand unpacking; subtraction is addition with B's sign flipped.
  logic        sa_s, sb_s;
  logic [7:0]  ea_s, eb_s;
  logic [22:0] fa_s, fb_s;
  logic        op_mul_s;
  logic        a_nan_s, b_nan_s, a_inf_s, b_inf_s, a_zero_s, b_zero_s;

  assign sa_s     = bus.A[31];
  assign ea_s     = bus.A[30:23];
  assign fa_s     = bus.A[22:0];
  assign sb_s     = bus.B[31] ^ (bus.opcode == 2'b01);
  assign eb_s     = bus.B[30:23];
  assign fb_s     = bus.B[22:0];
  assign op_mul_s = (bus.opcode == 2'b10);
  assign a_nan_s  = (ea_s == 8'hFF) && (fa_s != 23'd0);
  assign b_nan_s  = (eb_s == 8'hFF) && (fb_s != 23'd0);
  assign a_inf_s  = (ea_s == 8'hFF) && (fa_s == 23'd0);
  assign b_inf_s  = (eb_s == 8'hFF) && (fb_s == 23'd0);
  assign a_zero_s = (ea_s == 8'd0);
  assign b_zero_s = (eb_s == 8'd0);

  logic        s1_spec_d, s1_spec_q;
  logic [31:0] s1_sval_d, s1_sval_q;
  logic        s1_mul_d, s1_mul_q;
  logic        s1_sign_d, s1_sign_q;
  logic signed [9:0] s1_exp_d, s1_exp_q;
  logic [23:0] s1_mbig_d, s1_mbig_q;
  logic [26:0] s1_msml_d, s1_msml_q;
  logic        s1_sub_d, s1_sub_q;
  logic [47:0] s1_prod_d, s1_prod_q;

  logic        a_big_s;
  logic [7:0]  e_big_s, e_sml_s, diff_s;
  logic [4:0]  shamt_s;
  logic [23:0] m_sml_s;
  logic [49:0] wide_s;

  // Stage-1 datapath: magnitude swap, aligned smaller mantissa with G/R/sticky, product.
  always_comb begin
    a_big_s   = ({ea_s, fa_s} >= {eb_s, fb_s});
    e_big_s   = a_big_s ? ea_s : eb_s;
    e_sml_s   = a_big_s ? eb_s : ea_s;
    m_sml_s   = a_big_s ? {1'b1, fb_s} : {1'b1, fa_s};
    diff_s    = e_big_s - e_sml_s;
    shamt_s   = (diff_s > 8'd31) ? 5'd31 : diff_s[4:0];
    wide_s    = {m_sml_s, 26'd0} >> shamt_s;
    s1_msml_d = {wide_s[49:24], |wide_s[23:0]};
    s1_mbig_d = a_big_s ? {1'b1, fa_s} : {1'b1, fb_s};
    s1_sub_d  = (sa_s != sb_s);
    s1_mul_d  = op_mul_s;
    s1_prod_d = 48'({1'b1, fa_s}) * 48'({1'b1, fb_s});
    if (op_mul_s) begin
      s1_sign_d = sa_s ^ sb_s;
      s1_exp_d  = $signed({2'b00, ea_s}) + $signed({2'b00, eb_s}) - 10'sd127;
    end else begin
      s1_sign_d = a_big_s ? sa_s : sb_s;
      s1_exp_d  = $signed({2'b00, e_big_s});
    end
  end

  // Special-value results bypass the arithmetic path entirely.
  always_comb begin
    s1_spec_d = 1'b1;
    s1_sval_d = 32'h0000_0000;
    if (bus.opcode == 2'b11) begin
      s1_sval_d = 32'h0000_0000;
    end else if (a_nan_s || b_nan_s) begin
      s1_sval_d = QNAN;
    end else if (op_mul_s) begin
      if ((a_inf_s && b_zero_s) || (a_zero_s && b_inf_s)) begin
        s1_sval_d = QNAN;
      end else if (a_inf_s || b_inf_s) begin
        s1_sval_d = {sa_s ^ sb_s, 8'hFF, 23'd0};
      end else if (a_zero_s || b_zero_s) begin
        s1_sval_d = {sa_s ^ sb_s, 31'd0};
      end else begin
        s1_spec_d = 1'b0;
      end
    end else begin
      if (a_inf_s && b_inf_s) begin
        s1_sval_d = (sa_s == sb_s) ? {sa_s, 8'hFF, 23'd0} : QNAN;
      end else if (a_inf_s) begin
        s1_sval_d = {sa_s, 8'hFF, 23'd0};
      end else if (b_inf_s) begin
        s1_sval_d = {sb_s, 8'hFF, 23'd0};
      end else if (a_zero_s && b_zero_s) begin
        s1_sval_d = {sa_s & sb_s, 31'd0};
      end else if (a_zero_s) begin
        s1_sval_d = {sb_s, eb_s, fb_s};
      end else if (b_zero_s) begin
        s1_sval_d = {sa_s, ea_s, fa_s};
      end else begin
        s1_spec_d = 1'b0;
      end
    end
  end

  logic [27:0]       sum_s;
  logic [4:0]        lz_s;
  logic [26:0]       n_s;
  logic signed [9:0] exp_n_s, exp_r_s;
  logic              up_s;
  logic [24:0]       m25_s;
  logic [22:0]       frac_s;
  logic [31:0]       o_d, o_q;

  // Stage-2 datapath: add/sub, normalise to {1.frac, G, R, S}, round, pack.
  always_comb begin
    sum_s = s1_sub_q ? ({1'b0, s1_mbig_q, 3'd0} - {1'b0, s1_msml_q})
                     : ({1'b0, s1_mbig_q, 3'd0} + {1'b0, s1_msml_q});
    lz_s  = lzc27(sum_s[26:0]);
    if (s1_mul_q) begin
      if (s1_prod_q[47]) begin
        n_s = {s1_prod_q[47:23], s1_prod_q[22], |s1_prod_q[21:0]};
      end else begin
        n_s = {s1_prod_q[46:22], s1_prod_q[21], |s1_prod_q[20:0]};
      end
      exp_n_s = s1_exp_q + $signed({9'd0, s1_prod_q[47]});
    end else if (sum_s[27]) begin
      n_s     = {sum_s[27:2], sum_s[1] | sum_s[0]};
      exp_n_s = s1_exp_q + 10'sd1;
    end else begin
      n_s     = sum_s[26:0] << lz_s;
      exp_n_s = s1_exp_q - $signed({5'd0, lz_s});
    end
    up_s    = n_s[2] & (n_s[3] | n_s[1] | n_s[0]);
    m25_s   = {1'b0, n_s[26:3]} + {24'd0, up_s};
    exp_r_s = exp_n_s + $signed({9'd0, m25_s[24]});
    frac_s  = m25_s[24] ? m25_s[23:1] : m25_s[22:0];

    if (s1_spec_q) begin
      o_d = s1_sval_q;
    end else if (!s1_mul_q && (sum_s == 28'd0)) begin
      o_d = 32'h0000_0000;
    end else if (exp_r_s >= 10'sd255) begin
      o_d = {s1_sign_q, 8'hFF, 23'd0};
    end else if (exp_r_s <= 10'sd0) begin
      o_d = {s1_sign_q, 31'd0};
    end else begin
      o_d = {s1_sign_q, exp_r_s[7:0], frac_s};
    end
  end

  // Pipeline registers; reset discards anything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_spec_q <= 1'b0;
      s1_sval_q <= 32'h0000_0000;
      s1_mul_q  <= 1'b0;
      s1_sign_q <= 1'b0;
      s1_exp_q  <= 10'sd0;
      s1_mbig_q <= 24'd0;
      s1_msml_q <= 27'd0;
      s1_sub_q  <= 1'b0;
      s1_prod_q <= 48'd0;
      o_q       <= 32'h0000_0000;
    end else begin
      s1_spec_q <= s1_spec_d;
      s1_sval_q <= s1_sval_d;
      s1_mul_q  <= s1_mul_d;
      s1_sign_q <= s1_sign_d;
      s1_exp_q  <= s1_exp_d;
      s1_mbig_q <= s1_mbig_d;
      s1_msml_q <= s1_msml_d;
      s1_sub_q  <= s1_sub_d;
      s1_prod_q <= s1_prod_d;
      o_q       <= o_d;
    end
  end

  assign bus.O = o_q;

endmodule

// File: tb/tb_fpu.sv
// Directed self-checking bench for fpu: arithmetic vectors, specials, pipelining and async reset.
module tb_fpu;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  fpu_if bus_if ();

  fpu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic exec(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                      output logic [31:0] o);
    @(negedge clk);
    bus_if.A      = a;
    bus_if.B      = b;
    bus_if.opcode = op;
    @(posedge clk);
    @(posedge clk);
    #1;
    o = bus_if.O;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus_if.A      = 32'h3F80_0000;
    bus_if.B      = 32'h3F80_0000;
    bus_if.opcode = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus_if.O !== 32'h0000_0000) begin
      errors++;
      $display("FAIL reset_state: O=%h expected 00000000", bus_if.O);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add();
    logic [31:0] ta [0:10];
    logic [31:0] tb [0:10];
    logic [31:0] te [0:10];
    logic [31:0] o;
    ta = '{32'h71E3A159, 32'hC2342E41, 32'h367329EC, 32'h17CBEB11, 32'hB77D1B3E, 32'h3FC00000,
           32'h3F800000, 32'h3F800001, 32'h00400000, 32'h7F7FFFFF, 32'h80000000};
    tb = '{32'hF24CABEF, 32'h2E3C8F5C, 32'h51ABA17E, 32'h384BD1D7, 32'h45DECA4E, 32'h3FC00000,
           32'h33800000, 32'h33800000, 32'h3F800000, 32'h7F7FFFFF, 32'h80000000};
    te = '{32'hF1B5B685, 32'hC2342E41, 32'h51ABA17E, 32'h384BD1D7, 32'h45DECA4E, 32'h40400000,
           32'h3F800000, 32'h3F800002, 32'h3F800000, 32'h7F800000, 32'h80000000};
    for (int i = 0; i < 11; i++) begin
      exec(ta[i], tb[i], 2'b00, o);
      checks++;
      if (o !== te[i]) begin
        errors++;
        $display("FAIL add[%0d]: %h+%h O=%h expected %h", i, ta[i], tb[i], o, te[i]);
      end
    end
  endtask

  task automatic test_sub();
    logic [31:0] ta [0:4];
    logic [31:0] tb [0:4];
    logic [31:0] te [0:4];
    logic [31:0] o;
    ta = '{32'h3F800000, 32'h40400000, 32'h3F800000, 32'h7F800000, 32'h7F800000};
    tb = '{32'h3F800000, 32'h3F800000, 32'h40400000, 32'h3F800000, 32'h7F800000};
    te = '{32'h00000000, 32'h40000000, 32'hC0000000, 32'h7F800000, 32'h7FC00000};
    for (int i = 0; i < 5; i++) begin
      exec(ta[i], tb[i], 2'b01, o);
      checks++;
      if (o !== te[i]) begin
        errors++;
        $display("FAIL sub[%0d]: %h-%h O=%h expected %h", i, ta[i], tb[i], o, te[i]);
      end
    end
  endtask

  task automatic test_mul();
    logic [31:0] ta [0:5];
    logic [31:0] tb [0:5];
    logic [31:0] te [0:5];
    logic [31:0] o;
    ta = '{32'h40000000, 32'h7F000000, 32'hC0000000, 32'h3F000000, 32'h00800000, 32'h3FC00000};
    tb = '{32'h40400000, 32'h7F000000, 32'h40400000, 32'h3F000000, 32'h00800000, 32'h3FC00000};
    te = '{32'h40C00000, 32'h7F800000, 32'hC0C00000, 32'h3E800000, 32'h00000000, 32'h40100000};
    for (int i = 0; i < 6; i++) begin
      exec(ta[i], tb[i], 2'b10, o);
      checks++;
      if (o !== te[i]) begin
        errors++;
        $display("FAIL mul[%0d]: %h*%h O=%h expected %h", i, ta[i], tb[i], o, te[i]);
      end
    end
  endtask

  task automatic test_special();
    logic [31:0] ta [0:4];
    logic [31:0] tb [0:4];
    logic [1:0]  top [0:4];
    logic [31:0] te [0:4];
    logic [31:0] o;
    ta  = '{32'h7F800000, 32'h00000000, 32'h7F800001, 32'h3F800000, 32'hFF800000};
    tb  = '{32'hFF800000, 32'h7F800000, 32'h3F800000, 32'h3F800000, 32'h40000000};
    top = '{2'b00, 2'b10, 2'b00, 2'b11, 2'b10};
    te  = '{32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'h00000000, 32'hFF800000};
    for (int i = 0; i < 5; i++) begin
      exec(ta[i], tb[i], top[i], o);
      checks++;
      if (o !== te[i]) begin
        errors++;
        $display("FAIL special[%0d]: %h op%b %h O=%h expected %h", i, ta[i], top[i], tb[i], o, te[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ta [0:5];
    logic [31:0] tb [0:5];
    logic [1:0]  top [0:5];
    logic [31:0] te [0:5];
    ta  = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h3FC00000, 32'h3F800000, 32'h3F000000};
    tb  = '{32'h3F800000, 32'h40400000, 32'h3F800000, 32'h3FC00000, 32'h3F800000, 32'h3F000000};
    top = '{2'b00, 2'b10, 2'b01, 2'b00, 2'b11, 2'b10};
    te  = '{32'h40000000, 32'h40C00000, 32'h40000000, 32'h40400000, 32'h00000000, 32'h3E800000};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i < 6) begin
        bus_if.A      = ta[i];
        bus_if.B      = tb[i];
        bus_if.opcode = top[i];
      end
      @(posedge clk);
      #1;
      if (i >= 1) begin
        checks++;
        if (bus_if.O !== te[i-1]) begin
          errors++;
          $display("FAIL b2b[%0d]: O=%h expected %h", i - 1, bus_if.O, te[i-1]);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] o;
    exec(32'h40000000, 32'h40400000, 2'b10, o);
    checks++;
    if (o !== 32'h40C00000) begin
      errors++;
      $display("FAIL rst_pre: O=%h expected 40c00000", o);
    end
    @(negedge clk);
    bus_if.A      = 32'h3F800000;
    bus_if.B      = 32'h3F800000;
    bus_if.opcode = 2'b00;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus_if.O !== 32'h0000_0000) begin
      errors++;
      $display("FAIL rst_async: O=%h expected 00000000", bus_if.O);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus_if.O !== 32'h0000_0000) begin
      errors++;
      $display("FAIL rst_hold: O=%h expected 00000000", bus_if.O);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus_if.O !== 32'h0000_0000) begin
      errors++;
      $display("FAIL rst_edge1: O=%h expected 00000000", bus_if.O);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus_if.O !== 32'h4000_0000) begin
      errors++;
      $display("FAIL rst_edge2: O=%h expected 40000000", bus_if.O);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_special();
    test_back_to_back();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpu.md
Name: fpu

Overview:
- Pipelined IEEE-754 single-precision arithmetic unit: add, subtract, multiply.
- Operands A, B and opcode are sampled on a clock edge; the registered result appears on O two rising edges later.
- Used as a shared arithmetic datapath block fed directly from register-file outputs; no handshake, one new operation accepted every cycle.

Parameters:
- LATENCY, 2, number of rising clk edges from operand sampling to O update; fixed, not to be overridden.

Ports:
- clk     input   1   system clock, rising-edge active
- rst     input   1   asynchronous, active-high reset
- A       input   32  operand A, IEEE-754 binary32 (sign[31], exp[30:23], frac[22:0])
- B       input   32  operand B, same format
- opcode  input   2   00 = A+B, 01 = A-B, 10 = A*B, 11 = reserved
- O       output  32  registered result, binary32

Behaviour:
- Reset: rst high clears all pipeline registers and O to 32'h00000000 immediately, regardless of clk.
  - Reset asserted mid-operation discards in-flight operations.
  - The first valid O appears 2 edges after rst deasserts with stable inputs.
- Pipeline:
  - Stage 1, edge 1: register A, B, opcode; unpack; classify special values; for add/sub compare exponents, swap so the larger magnitude is first, align the smaller mantissa (right shift keeping guard/round/sticky); for mul form the 24x24 mantissa product and exponent sum.
  - Stage 2, edge 2: add/subtract aligned mantissas; normalise (leading-zero count, left shift, or 1-bit right shift on carry); round; pack into O.
  - Throughput 1 op/cycle; O holds until the next stage-2 edge.
- Subtract: implemented as add with B sign inverted.
- Rounding: round-to-nearest, ties-to-even, using guard/round/sticky. Results must be within 2 ULP of the correctly rounded value; exact-RNE is the target.
- Alignment: exponent difference >= 26 yields the larger operand unchanged, after rounding.
- Exact cancellation (x + (-x)): O = +0 (32'h00000000).
- Denormals: inputs with exp=0 are treated as signed zero (flush-to-zero); results below the minimum normal flush to signed zero.
- Overflow: biased exponent >= 255 after rounding gives signed infinity (exp=255, frac=0).
- Special values:
  - Any NaN input gives canonical NaN 32'h7FC00000.
  - inf - inf gives NaN; 0 * inf gives NaN.
  - inf op finite gives the appropriately signed infinity.
- Multiply: result sign is signA XOR signB; exponent is eA + eB - 127, adjusted by normalisation.
- Opcode 11: O = 32'h00000000 after the same 2-cycle latency.
- No status flags are produced.

Test Plan:
- Add, large magnitudes: A=71E3A159, B=F24CABEF, op=00 -> O=F1B5B685 (±2 ULP) two edges later.
- Add, tiny operand absorbed: A=C2342E41, B=2E3C8F5C -> O=C2342E41. Also 367329EC + 51ABA17E -> 51ABA17E, 17CBEB11 + 384BD1D7 -> 384BD1D7, and B77D1B3E + 45DECA4E -> 45DECA4E.
- Sub and cancellation: A=3F800000, B=3F800000, op=01 -> O=00000000; A=40400000, B=3F800000, op=01 -> O=40000000.
- Mul: A=40000000, B=40400000, op=10 -> O=40C00000; A=7F000000, B=7F000000, op=10 -> O=7F800000 (overflow).
- Specials: A=7F800000, B=FF800000, op=00 -> 7FC00000; A=00000000, B=7F800000, op=10 -> 7FC00000.
- Pipelining and reset:
  - Issue back-to-back ops on consecutive cycles; each result must appear exactly 2 edges after its inputs.
  - Assert rst between edges with an op in flight; O must go to 00000000 at once and stay there until 2 edges after release.
